// File: rtl/abs_diff_pkg.sv
// -----------------------------------------------------------------------------
// abs_diff_pkg
// Shared definitions for the approximate-circuit error sweeper.
//   state_t    : sweeper FSM states (IDLE, SWEEP, DONE)
//   abs_diff_w : width of |a - b| for two unsigned n_out-bit words. The
//                magnitude of the difference never exceeds the larger operand,
//                so it always fits in n_out bits.
// -----------------------------------------------------------------------------
package abs_diff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int abs_diff_w(input int n_out);
        return n_out;
    endfunction

endpackage

// File: rtl/err_abs_cmp.sv
// -----------------------------------------------------------------------------
// err_abs_cmp
// Combinational unsigned absolute difference plus threshold compare.
// Ports:
//   exact  [N_OUT-1:0] : exact circuit response
//   approx [N_OUT-1:0] : approximate circuit response
//   diff               : |exact - approx|, no overflow possible
//   gt_et              : diff > ET
// -----------------------------------------------------------------------------
module err_abs_cmp
    import abs_diff_pkg::*;
#(
    parameter int N_OUT = 3,
    parameter int ET    = 2
) (
    input  logic [N_OUT-1:0]             exact,
    input  logic [N_OUT-1:0]             approx,
    output logic [abs_diff_w(N_OUT)-1:0] diff,
    output logic                         gt_et
);

    // Subtract the smaller from the larger so the result is never negative.
    always_comb begin
        if (exact >= approx) begin
            diff = exact - approx;
        end else begin
            diff = approx - exact;
        end
    end

    // ET may be wider than diff, so compare in int.
    assign gt_et = (int'(diff) > ET);

endmodule

// File: rtl/abs_diff_error_sweeper.sv
// -----------------------------------------------------------------------------
// abs_diff_error_sweeper
// Drives every input vector 0 .. 2^N_IN-1 into an exact and an approximate
// combinational circuit, one vector per cycle, and accumulates error stats.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begins a sweep (honoured only in IDLE or DONE)
//   vec_out    : vector currently applied to both circuits (registered)
//   exact_in   : exact response to vec_out, same cycle
//   approx_in  : approximate response to vec_out, same cycle
//   busy       : sweep in progress
//   done       : sweep finished, results held until next start
//   max_err    : largest |exact - approx| of current/last sweep
//   err_cnt    : number of vectors where the responses differ
//   viol       : sticky, some difference exceeded ET
//   fail_vec   : first vector that set viol
//   pass       : done and no violation
//   dbg_state  : current FSM state, for observation only
// -----------------------------------------------------------------------------
module abs_diff_error_sweeper
    import abs_diff_pkg::*;
#(
    parameter int N_IN         = 4,
    parameter int N_OUT        = 3,
    parameter int ET           = 2,
    parameter int STOP_ON_VIOL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  exact_in,
    input  logic [N_OUT-1:0]  approx_in,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  max_err,
    output logic [N_IN:0]     err_cnt,
    output logic              viol,
    output logic [N_IN-1:0]   fail_vec,
    output logic              pass,
    output state_t            dbg_state
);

    localparam int DIFF_W = abs_diff_w(N_OUT);
    localparam logic [N_IN-1:0] VEC_ONE = 1;
    localparam logic [N_IN:0]   CNT_ONE = 1;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     cnt_q, cnt_d;
    logic [N_OUT-1:0]    max_err_q, max_err_d;
    logic [N_IN:0]       err_cnt_q, err_cnt_d;
    logic                viol_q, viol_d;
    logic [N_IN-1:0]     fail_vec_q, fail_vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic [DIFF_W-1:0]   diff;
    logic                gt_et;
    logic                first_viol;

    err_abs_cmp #(
        .N_OUT (N_OUT),
        .ET    (ET)
    ) u_cmp (
        .exact  (exact_in),
        .approx (approx_in),
        .diff   (diff),
        .gt_et  (gt_et)
    );

    assign first_viol = gt_et && !viol_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        max_err_d  = max_err_q;
        err_cnt_d  = err_cnt_q;
        viol_d     = viol_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SWEEP;
                    cnt_d      = '0;
                    max_err_d  = '0;
                    err_cnt_d  = '0;
                    viol_d     = 1'b0;
                    fail_vec_d = '0;
                end
            end
            ST_SWEEP: begin
                if (diff > max_err_q) begin
                    max_err_d = diff;
                end
                if (diff != '0) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
                if (first_viol) begin
                    viol_d     = 1'b1;
                    fail_vec_d = cnt_q;
                end
                // Counter parks on the last evaluated vector so vec_out
                // holds in DONE and never wraps into a second pass.
                if ((cnt_q == '1) || ((STOP_ON_VIOL != 0) && first_viol)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + VEC_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SWEEP);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && !viol_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            max_err_q  <= '0;
            err_cnt_q  <= '0;
            viol_q     <= 1'b0;
            fail_vec_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_err_q  <= max_err_d;
            err_cnt_q  <= err_cnt_d;
            viol_q     <= viol_d;
            fail_vec_q <= fail_vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign vec_out   = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign max_err   = max_err_q;
    assign err_cnt   = err_cnt_q;
    assign viol      = viol_q;
    assign fail_vec  = fail_vec_q;
    assign pass      = pass_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_abs_diff_error_sweeper.sv
// -----------------------------------------------------------------------------
// tb_abs_diff_error_sweeper
// Two sweeper instances share clock and reset: dut0 runs the full sweep on a
// violation, dut1 stops on the first violation. Both see the same behavioural
// circuit models, selected by `mode`:
//   0: approx == exact
//   1: approx == exact ^ 1 on every vector
//   2: approx == exact - 3 on vector 5 only
// -----------------------------------------------------------------------------
module tb_abs_diff_error_sweeper;
    import abs_diff_pkg::*;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [3:0]  vec_out0, vec_out1;
    logic [2:0]  exact0, approx0, exact1, approx1;
    logic        busy0, done0, viol0, pass0;
    logic        busy1, done1, viol1, pass1;
    logic [2:0]  max_err0, max_err1;
    logic [4:0]  err_cnt0, err_cnt1;
    logic [3:0]  fail_vec0, fail_vec1;
    state_t      st0, st1;

    int mode;
    int errors;
    int checks;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_approx(input int m, input logic [3:0] v);
        logic [2:0] e;
        e = v[2:0];
        case (m)
            1:       return e ^ 3'b001;
            2:       return (v == 4'd5) ? (e - 3'd3) : e;
            default: return e;
        endcase
    endfunction

    always_comb begin
        exact0  = vec_out0[2:0];
        approx0 = model_approx(mode, vec_out0);
        exact1  = vec_out1[2:0];
        approx1 = model_approx(mode, vec_out1);
    end

    abs_diff_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(2), .STOP_ON_VIOL(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .vec_out(vec_out0),
        .exact_in(exact0), .approx_in(approx0), .busy(busy0), .done(done0),
        .max_err(max_err0), .err_cnt(err_cnt0), .viol(viol0),
        .fail_vec(fail_vec0), .pass(pass0), .dbg_state(st0)
    );

    abs_diff_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(2), .STOP_ON_VIOL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_out(vec_out1),
        .exact_in(exact1), .approx_in(approx1), .busy(busy1), .done(done1),
        .max_err(max_err1), .err_cnt(err_cnt1), .viol(viol1),
        .fail_vec(fail_vec1), .pass(pass1), .dbg_state(st1)
    );

    // driver tasks: called on a negedge, return on the first negedge with busy low
    task automatic sweep0(output int cyc);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (busy0 === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic sweep1(output int cyc);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (busy1 === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({vec_out0, max_err0, err_cnt0, viol0, fail_vec0, busy0, done0, pass0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got vec=%0d max=%0d cnt=%0d viol=%b fv=%0d busy=%b done=%b pass=%b, want all 0",
                     vec_out0, max_err0, err_cnt0, viol0, fail_vec0, busy0, done0, pass0);
        end
        checks++;
        if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d, want IDLE", st0, st1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy0, done0);
        end
    endtask

    task automatic test_identical();
        int cyc;
        mode = 0;
        sweep0(cyc);
        checks++;
        if (cyc !== 16 || done0 !== 1'b1) begin
            errors++;
            $display("FAIL ident_len: got cycles=%0d done=%b, want 16 1", cyc, done0);
        end
        checks++;
        if (max_err0 !== 3'd0 || err_cnt0 !== 5'd0 || viol0 !== 1'b0 || pass0 !== 1'b1) begin
            errors++;
            $display("FAIL ident_stats: got max=%0d cnt=%0d viol=%b pass=%b, want 0 0 0 1",
                     max_err0, err_cnt0, viol0, pass0);
        end
        checks++;
        if (vec_out0 !== 4'd15) begin
            errors++;
            $display("FAIL ident_last_vec: got %0d, want 15", vec_out0);
        end
    endtask

    task automatic test_xor1();
        int cyc;
        mode = 1;
        sweep0(cyc);
        checks++;
        if (cyc !== 16 || max_err0 !== 3'd1 || err_cnt0 !== 5'd16 || viol0 !== 1'b0 || pass0 !== 1'b1) begin
            errors++;
            $display("FAIL xor1_stats: got cyc=%0d max=%0d cnt=%0d viol=%b pass=%b, want 16 1 16 0 1",
                     cyc, max_err0, err_cnt0, viol0, pass0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || err_cnt0 !== 5'd16 || max_err0 !== 3'd1 || vec_out0 !== 4'd15) begin
            errors++;
            $display("FAIL xor1_hold: got done=%b cnt=%0d max=%0d vec=%0d, want 1 16 1 15",
                     done0, err_cnt0, max_err0, vec_out0);
        end
    endtask

    task automatic test_stop_on_viol();
        int cyc;
        mode = 2;
        sweep1(cyc);
        checks++;
        if (cyc !== 6 || done1 !== 1'b1 || vec_out1 !== 4'd5) begin
            errors++;
            $display("FAIL stop_len: got cyc=%0d done=%b vec=%0d, want 6 1 5", cyc, done1, vec_out1);
        end
        checks++;
        if (viol1 !== 1'b1 || fail_vec1 !== 4'd5 || err_cnt1 !== 5'd1 || max_err1 !== 3'd3 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL stop_stats: got viol=%b fv=%0d cnt=%0d max=%0d pass=%b, want 1 5 1 3 0",
                     viol1, fail_vec1, err_cnt1, max_err1, pass1);
        end
    endtask

    task automatic test_no_stop();
        int cyc;
        mode = 2;
        sweep0(cyc);
        checks++;
        if (cyc !== 16 || done0 !== 1'b1) begin
            errors++;
            $display("FAIL nostop_len: got cyc=%0d done=%b, want 16 1", cyc, done0);
        end
        checks++;
        if (viol0 !== 1'b1 || fail_vec0 !== 4'd5 || err_cnt0 !== 5'd1 || max_err0 !== 3'd3 || pass0 !== 1'b0) begin
            errors++;
            $display("FAIL nostop_stats: got viol=%b fv=%0d cnt=%0d max=%0d pass=%b, want 1 5 1 3 0",
                     viol0, fail_vec0, err_cnt0, max_err0, pass0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        int guard;
        mode = 1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (vec_out0 !== 4'd7 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (vec_out0 !== 4'd7) begin
            errors++;
            $display("FAIL midrst_reach7: got vec=%0d, want 7", vec_out0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vec_out0, max_err0, err_cnt0, viol0, fail_vec0, busy0, done0, pass0} !== '0 || st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL midrst_async: got vec=%0d max=%0d cnt=%0d busy=%b st=%0d, want 0 0 0 0 IDLE",
                     vec_out0, max_err0, err_cnt0, busy0, st0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== ST_IDLE) begin
            errors++;
            $display("FAIL midrst_idle: got busy=%b done=%b st=%0d, want 0 0 IDLE", busy0, done0, st0);
        end
        sweep0(cyc);
        checks++;
        if (cyc !== 16 || err_cnt0 !== 5'd16 || max_err0 !== 3'd1 || pass0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_resweep: got cyc=%0d cnt=%0d max=%0d pass=%b, want 16 16 1 1",
                     cyc, err_cnt0, max_err0, pass0);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        mode = 1;
        start0 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy0 === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== 16 || done0 !== 1'b1 || err_cnt0 !== 5'd16 || max_err0 !== 3'd1) begin
            errors++;
            $display("FAIL held_first: got cyc=%0d done=%b cnt=%0d max=%0d, want 16 1 16 1",
                     cyc, done0, err_cnt0, max_err0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || vec_out0 !== 4'd0 || err_cnt0 !== 5'd0 || max_err0 !== 3'd0) begin
            errors++;
            $display("FAIL held_restart: got busy=%b vec=%0d cnt=%0d max=%0d, want 1 0 0 0",
                     busy0, vec_out0, err_cnt0, max_err0);
        end
        start0 = 1'b0;
        cyc = 0;
        while (busy0 === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== 16 || done0 !== 1'b1 || err_cnt0 !== 5'd16) begin
            errors++;
            $display("FAIL held_second: got cyc=%0d done=%b cnt=%0d, want 16 1 16", cyc, done0, err_cnt0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mode   = 0;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        test_reset();
        test_identical();
        test_xor1();
        test_stop_on_viol();
        test_no_stop();
        test_reset_mid_sweep();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/abs_diff_error_sweeper.md
ABS_DIFF_ERROR_SWEEPER -- requirements
Module: abs_diff_error_sweeper

Interface
Parameters:
REQ-001 N_IN, default 4: width of the input vector driven to the circuits under test.
REQ-002 N_OUT, default 3: width of the exact and approximate output words.
REQ-003 ET, default 2: error threshold, the maximum allowed absolute difference.
REQ-004 STOP_ON_VIOL, default 0: when 1, the sweep ends on the first threshold violation.

Ports:
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  starts a sweep; sampled only in IDLE or DONE.
REQ-008 vec_out  out  N_IN  input vector driven to both the exact and the approximate combinational circuit.
REQ-009 exact_in  in  N_OUT  exact circuit response to vec_out, same cycle.
REQ-010 approx_in  in  N_OUT  approximate circuit response to vec_out, same cycle.
REQ-011 busy  out  1  high while in SWEEP.
REQ-012 done  out  1  high while in DONE.
REQ-013 max_err  out  N_OUT  largest absolute difference seen in the current or last sweep.
REQ-014 err_cnt  out  N_IN+1  number of vectors where exact_in != approx_in.
REQ-015 viol  out  1  sticky; set when any difference exceeds ET.
REQ-016 fail_vec  out  N_IN  first vector that set viol.
REQ-017 pass  out  1  equals done AND NOT viol.

Function
REQ-018 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-019 IDLE to SWEEP on start=1: clear the vector counter, max_err, err_cnt, viol and fail_vec.
REQ-020 In SWEEP, vec_out SHALL equal the vector counter (registered), and the responses SHALL be evaluated in the same cycle.
REQ-021 Difference SHALL be unsigned: diff = (exact_in >= approx_in) ? exact_in - approx_in : approx_in - exact_in, N_OUT bits, no overflow.
REQ-022 Each SWEEP cycle: max_err SHALL become max(max_err, diff); err_cnt SHALL increment if diff != 0.
REQ-023 Each SWEEP cycle: if diff > ET and viol = 0, viol SHALL be set and fail_vec SHALL capture the counter.
REQ-024 After evaluating the all-ones vector (2^N_IN - 1), the FSM SHALL go to DONE; the counter SHALL not wrap into a second pass.
REQ-025 With STOP_ON_VIOL=1, the FSM SHALL go to DONE in the cycle after the first violation; that vector's error SHALL still be counted.
REQ-026 A full sweep SHALL take exactly 2^N_IN SWEEP cycles (16 at defaults), with done asserted in the following cycle.
REQ-027 start SHALL be ignored during SWEEP.
REQ-028 start in DONE SHALL re-clear the statistics and enter SWEEP directly, without passing through IDLE.
REQ-029 Result outputs SHALL hold stable in DONE until the next start.
REQ-030 err_cnt SHALL reach 2^N_IN without overflow, which is why it is N_IN+1 bits wide.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and vec_out, max_err, err_cnt, viol, fail_vec, busy, done and pass SHALL all be 0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep immediately, with no partial result retained.
REQ-033 After reset deasserts, the first sweep SHALL start only on a new start.

Structure
REQ-034 The state enum and the abs-diff width helper SHALL live in the shared package abs_diff_pkg.
REQ-035 The absolute-difference/compare datapath SHALL be one sub-module, err_abs_cmp (inputs exact, approx; outputs diff, gt_et).
REQ-036 The FSM, counter and statistics registers SHALL be in the top module.

Verification
REQ-037 Identical exact/approx models, start pulse -> done after 16 SWEEP cycles, max_err=0, err_cnt=0, viol=0, pass=1.
REQ-038 approx = exact XOR 1 for all vectors -> max_err=1, err_cnt=16, viol=0, pass=1.
REQ-039 Only vector 5 differs, by 3, with STOP_ON_VIOL=1 -> viol=1, fail_vec=5, err_cnt=1, done on the cycle after vec_out=5, pass=0.
REQ-040 Same stimulus as REQ-039 but STOP_ON_VIOL=0 -> full 16 vectors, fail_vec=5, max_err=3, pass=0.
REQ-041 rst pulsed at vec_out=7 -> all outputs 0 asynchronously, IDLE, and the next start yields a clean full sweep.
REQ-042 start held high throughout SWEEP and then into DONE -> the first sweep is unaffected, and a second sweep begins with cleared statistics.
